// File: rtl/madd_err_sweeper.sv
// Exhaustive sweep driver and error checker for an exact/approximate circuit pair:
// applies every input vector, compares both results and accumulates error statistics.
module madd_err_sweeper #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 4,
    parameter int ET    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       vec_out,
    input  logic [N_OUT-1:0]      exact_in,
    input  logic [N_OUT-1:0]      approx_in,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT-1:0]      max_err,
    output logic [N_IN:0]         err_count,
    output logic [N_IN+N_OUT-1:0] err_sum,
    output logic [N_IN:0]         fail_count,
    output logic [N_IN-1:0]       first_fail_vec,
    output logic                  pass
);

    typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;

    localparam logic [N_IN-1:0]  LastVec   = '1;
    localparam logic [N_OUT-1:0] ErrThresh = N_OUT'(ET);

    state_t                  state_q, state_d;
    logic [N_IN-1:0]         vec_q, vec_d;
    logic [N_OUT-1:0]        s1Exact_q, s1Exact_d;
    logic [N_OUT-1:0]        s1Approx_q, s1Approx_d;
    logic [N_IN-1:0]         s1Vec_q, s1Vec_d;
    logic                    s1Valid_q, s1Valid_d;
    logic [N_OUT-1:0]        maxErr_q, maxErr_d;
    logic [N_IN:0]           errCount_q, errCount_d;
    logic [N_IN+N_OUT-1:0]   errSum_q, errSum_d;
    logic [N_IN:0]           failCount_q, failCount_d;
    logic [N_IN-1:0]         firstFail_q, firstFail_d;
    logic                    pass_q, pass_d;

    logic                    startOk;
    logic [N_OUT-1:0]        absErr;
    logic                    overThresh;

    assign startOk    = start && !abort;
    // Unsigned magnitude of the difference; ordering the subtraction keeps it in N_OUT bits.
    assign absErr     = (s1Exact_q >= s1Approx_q) ? (s1Exact_q - s1Approx_q)
                                                  : (s1Approx_q - s1Exact_q);
    assign overThresh = absErr > ErrThresh;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        s1Exact_d   = s1Exact_q;
        s1Approx_d  = s1Approx_q;
        s1Vec_d     = s1Vec_q;
        s1Valid_d   = 1'b0;
        maxErr_d    = maxErr_q;
        errCount_d  = errCount_q;
        errSum_d    = errSum_q;
        failCount_d = failCount_q;
        firstFail_d = firstFail_q;
        pass_d      = pass_q;

        // Stage 2: fold the previous cycle's sample into the statistics.
        if (s1Valid_q && (state_q == SWEEP || state_q == FLUSH)) begin
            if (absErr > maxErr_q) begin
                maxErr_d = absErr;
            end
            errSum_d   = errSum_q + {{N_IN{1'b0}}, absErr};
            errCount_d = errCount_q + {{N_IN{1'b0}}, (absErr != '0)};
            if (overThresh) begin
                failCount_d = failCount_q + 1'b1;
                if (failCount_q == '0) begin
                    firstFail_d = s1Vec_q;
                end
            end
        end

        case (state_q)
            IDLE: begin
                vec_d = '0;
                if (startOk) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    s1Exact_d  = exact_in;
                    s1Approx_d = approx_in;
                    s1Vec_d    = vec_q;
                    s1Valid_d  = 1'b1;
                    if (vec_q == LastVec) begin
                        state_d = FLUSH;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = DONE;
                    pass_d  = (failCount_d == '0);
                end
            end
            DONE: begin
                vec_d   = '0;
                state_d = startOk ? SWEEP : IDLE;
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase

        // A newly accepted sweep starts from clean statistics.
        if ((state_q == IDLE || state_q == DONE) && startOk) begin
            maxErr_d    = '0;
            errCount_d  = '0;
            errSum_d    = '0;
            failCount_d = '0;
            firstFail_d = '0;
            pass_d      = 1'b0;
            s1Valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            s1Exact_q   <= '0;
            s1Approx_q  <= '0;
            s1Vec_q     <= '0;
            s1Valid_q   <= 1'b0;
            maxErr_q    <= '0;
            errCount_q  <= '0;
            errSum_q    <= '0;
            failCount_q <= '0;
            firstFail_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            s1Exact_q   <= s1Exact_d;
            s1Approx_q  <= s1Approx_d;
            s1Vec_q     <= s1Vec_d;
            s1Valid_q   <= s1Valid_d;
            maxErr_q    <= maxErr_d;
            errCount_q  <= errCount_d;
            errSum_q    <= errSum_d;
            failCount_q <= failCount_d;
            firstFail_q <= firstFail_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q == SWEEP) || (state_q == FLUSH);
    assign done           = (state_q == DONE);
    assign max_err        = maxErr_q;
    assign err_count      = errCount_q;
    assign err_sum        = errSum_q;
    assign fail_count     = failCount_q;
    assign first_fail_vec = firstFail_q;
    assign pass           = pass_q;

endmodule

// File: doc/madd_err_sweeper.md
Name: madd_err_sweeper

Overview:
- Sequential stimulus/checker at the driving end of the 6-in/4-out approximate multiply-add interface.
- Exhaustively drives every input vector onto the shared input bus of an exact circuit and its approximated (SOP-XPATed) counterpart.
- Reads both 4-bit result buses back, treats them as unsigned, and accumulates error statistics.
- Flags pass/fail against the error threshold; serves as the on-chip error-verification harness for generated approximate netlists.

Parameters:
N_IN, 6, width of input vector bus (sweep covers 2^N_IN vectors)
N_OUT, 4, width of each result bus (unsigned)
ET, 1, maximum permitted absolute error per vector

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
abort  input  1  cancel sweep in progress; return to IDLE
vec_out  output  N_IN  drives in0..in(N_IN-1) of both circuits; bit i -> in_i
exact_in  input  N_OUT  out0..out(N_OUT-1) of exact circuit
approx_in  input  N_OUT  out0..out(N_OUT-1) of approximate circuit
busy  output  1  high in SWEEP and FLUSH
done  output  1  one-cycle pulse when results are valid
max_err  output  N_OUT  largest |exact-approx| over sweep
err_count  output  N_IN+1  number of vectors with nonzero error
err_sum  output  N_IN+N_OUT  sum of |exact-approx| over sweep
fail_count  output  N_IN+1  number of vectors with error > ET
first_fail_vec  output  N_IN  lowest vector with error > ET (0 if none)
pass  output  1  1 iff fail_count==0 after completed sweep

Behaviour:
- Reset: state=IDLE; all outputs and internal sample registers 0, including pass.
- States: IDLE, SWEEP, FLUSH, DONE.
- IDLE:
  - vec_out holds 0.
  - start=1 -> SWEEP; clear all accumulators, pass, first_fail_vec and the sample-valid flag.
- SWEEP:
  - vec_out = v, starting at 0 on the first SWEEP cycle and incrementing by 1 each cycle.
  - Both circuits are combinational, so at the end of each cycle register (exact_in, approx_in, v) into stage-1 with valid=1.
  - Stage 2 runs in the following cycle:
    - d = |exact-approx|, computed in N_OUT+1 bits, result fits in N_OUT.
    - max_err = max(max_err, d).
    - err_sum += d.
    - err_count += (d!=0).
    - fail_count += (d>ET).
    - If d>ET and fail_count was 0 before this update, first_fail_vec = v.
  - When v = 2^N_IN-1 is applied: go to FLUSH next cycle. vec_out does not wrap; it holds 2^N_IN-1.
- FLUSH: stage 2 accumulates the last sample; no new sample is captured. Next state DONE.
- DONE:
  - done=1 for exactly this cycle; pass = (fail_count==0).
  - Next state IDLE, vec_out returns to 0.
  - start=1 in DONE starts a new sweep directly (SWEEP next cycle).
- Results (max_err…pass) hold their values from DONE until the next accepted start or rst.
- Latency: start high at edge k -> SWEEP cycles k+1..k+2^N_IN, FLUSH at k+2^N_IN+1, done at k+2^N_IN+2 (k+66 at defaults).
- start in SWEEP/FLUSH: ignored.
- abort has priority over start.
  - abort=1 in SWEEP or FLUSH -> IDLE next cycle.
  - No done pulse; pass forced 0; remaining statistics are don't-care until the next start.
  - abort in IDLE or DONE: no effect on state, except in DONE where it suppresses a simultaneous start.
- rst has priority over abort and start at any point, including mid-sweep.
- Counters cannot overflow at defaults: err_count max 64 fits 7 bits; err_sum max 64*15=960 fits 10 bits.

Test Plan:
- approx_in tied to exact_in, start pulse -> done exactly 66 cycles after start edge; max_err=0, err_count=0, err_sum=0, fail_count=0, first_fail_vec=0, pass=1.
- approx_in = exact_in XOR 4'b0001 -> err_count=64, err_sum=64, max_err=1, fail_count=0, pass=1 (ET=1).
- Model approx = exact except at vector 37, where exact=9 and approx=6 -> err_count=1, err_sum=3, max_err=3, fail_count=1, first_fail_vec=37, pass=0.
- Model with errors of 2 at vectors 5 and 50 -> fail_count=2, first_fail_vec=5, max_err=2, err_sum=4, pass=0.
- start held high for the whole sweep plus a second pulse at cycle 20 -> single sweep and single done; start held into the DONE cycle -> back-to-back sweep with accumulators cleared.
- abort at SWEEP cycle 30 -> IDLE next cycle, vec_out=0, no done, pass=0; rst asserted mid-sweep -> all outputs 0 the next cycle; a fresh start then completes normally.
